led_reg_pwm: RTL
================

# led_reg_pwm

Register file and PWM engine downstream of the I2C controller. It holds the eight 8-bit LED registers at 0x0–0x7 and services the single-cycle `reg_*` strobe interface. It drives the four `leds` outputs with per-channel PWM, group dimming and sleep, all timed from the internal 400 kHz oscillator clock.

## Interface
- `CNT_W`, default 8: PWM counter width. Duty registers are the same width.
- `ID_VALUE`, default 8'h96: constant returned when reading address 0x7.
- `clk_osc` input 1: internal oscillator clock; the only clock in the block.
- `reset_n` input 1: reset. **One clock; reset is asynchronous and active-low.**
- `reg_addr` input 3: register address, 0x0–0x7.
- `reg_wdata` input 8: write data.
- `reg_write` input 1: write strobe; one cycle per transaction.
- `reg_read` input 1: read strobe; one cycle per transaction.
- `reg_rdata` output 8: read data, registered.
- `sleep` output 1: MODE[4].
- `leds` output 4: LED drive; 1 = on. Registered.

## Operation
- **Register map and reset values:**
  - 0x0 MODE = 0x10. Bit 4 is SLEEP. The other bits are read/write storage only.
  - 0x1–0x4 PWM0–PWM3 = 0x00. Per-LED duty.
  - 0x5 GRPPWM = 0xFF. Group duty.
  - 0x6 LEDOUT = 0x00. Bits [2i+1:2i] select the mode of LED i.
  - 0x7 ID: read-only, returns `ID_VALUE`. Writes to it are ignored.
- **LEDOUT modes per LED:**
  - 00: off.
  - 01: fully on.
  - 10: individual PWM, lit while `cnt < pwm_sh[i]`.
  - 11: individual PWM AND group gate, lit while `cnt < pwm_sh[i]` and `gcnt < grp_sh`.
- **Counters:**
  - `cnt` free-runs 0→255→0.
  - `gcnt` increments once per `cnt` wrap (255→0) and wraps 255→0.
  - Both counters are held at 0 while SLEEP=1.
- **Shadow registers:**
  - `pwm_sh[0..3]` and `grp_sh` load from the live registers on the edge where `cnt` wraps 255→0.
  - While SLEEP=1 they load every cycle, so leaving sleep starts with the current values.
  - Duty changes therefore take effect only at a period boundary, which prevents glitches.
- **Sleep:** while SLEEP=1, `leds` = 0000 regardless of LEDOUT.
- **Duty range:** duty 0x00 is never lit. Duty 0xFF is lit 255 of 256 cycles.
- **Read:** on `reg_read`, `reg_rdata` ← value of `reg_addr` on the next edge. `reg_rdata` holds until the next read.
- **Simultaneous read and write to the same address:** the read returns the pre-write value.

## Timing
- **Reset:**
  - Registers take the values in the register map.
  - `cnt` = `gcnt` = 0; shadows = the register reset values.
  - `reg_rdata` = 0x00, `sleep` = 1, `leds` = 0000.
- **Write:** a write in cycle N updates the register at the end of cycle N.
  - A MODE or LEDOUT change appears on `leds` and `sleep` at the end of cycle N+1.
- **Write landing on the wrap cycle:** a PWM or GRPPWM write in the cycle where `cnt` = 255 misses that shadow load. It takes effect one full period later.
- **Read latency:** 1 cycle.
- **Output latency:** `leds` is one registered stage after the compare. LED i rises at the end of the cycle in which `cnt` = 0, when its duty is greater than 0.
- **Entering sleep:** `cnt` and `gcnt` clear, and `leds` go to 0, on the edge after the write completes.
- **Leaving sleep:** `cnt` starts at 0 on the edge after the write completes.
- **Reset mid-period:** everything returns to the reset values immediately. There is no partial state.

## Structure
- **Package `led_pkg`:**
  - Address constants `ADDR_MODE` … `ADDR_ID`.
  - `SLEEP_BIT` = 4.
  - Enum `ledout_mode_e` {OFF, ON, PWM, GRP}.
  - Register reset-value constants.
- **Sub-module `led_pwm_channel`, instantiated ×4:**
  - Holds the shadow duty and the mode decode.
  - Produces one registered LED bit from `cnt`, the group gate and `sleep`.
- **Top level:** register file, read mux, `cnt`/`gcnt` counters and `grp_sh`.

## Test plan
- **Reset and ID:** after reset, read every address. Expect 0x10, 0x00 ×4, 0xFF, 0x00, 0x96, with `leds` = 0000 and `sleep` = 1.
- **Full-on:** write MODE = 0x00 and LEDOUT = 0x55. Expect `leds` = 1111 two cycles after the LEDOUT write strobe, held constant.
- **Individual PWM:** write MODE = 0x00, PWM0 = 0x40 and LEDOUT = 0x02. Expect LED0 high for exactly 64 of every 256 cycles.
- **Duty boundary:**
  - With PWM1 = 0xFF and LEDOUT = 0x08, expect LED1 high 255 of every 256 cycles.
  - With PWM1 = 0x00, expect LED1 never high.
- **Group dimming:** with PWM2 = 0x80, GRPPWM = 0x40 and LEDOUT = 0x30, expect LED2 to pulse only during `gcnt` 0–63.
- **Shadow timing and sleep:**
  - Write PWM0 = 0x10 during the `cnt` = 255 cycle. Expect the old duty for one more period.
  - Then write MODE = 0x10 mid-period. Expect `leds` = 0000 and the counters at 0 within 1 cycle.
  - Then write MODE = 0x00. Expect the PWM to restart with `cnt` = 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and types for the LED register file / PWM engine.
// Register addresses, reset values and the per-LED output mode encoding.
package led_pkg;

    localparam logic [2:0] ADDR_MODE   = 3'h0;
    localparam logic [2:0] ADDR_PWM0   = 3'h1;
    localparam logic [2:0] ADDR_PWM1   = 3'h2;
    localparam logic [2:0] ADDR_PWM2   = 3'h3;
    localparam logic [2:0] ADDR_PWM3   = 3'h4;
    localparam logic [2:0] ADDR_GRPPWM = 3'h5;
    localparam logic [2:0] ADDR_LEDOUT = 3'h6;
    localparam logic [2:0] ADDR_ID     = 3'h7;

    localparam int SLEEP_BIT = 4;

    typedef enum logic [1:0] {
        OFF = 2'b00,
        ON  = 2'b01,
        PWM = 2'b10,
        GRP = 2'b11
    } ledout_mode_e;

    localparam logic [7:0] MODE_RST   = 8'h10;
    localparam logic [7:0] PWM_RST    = 8'h00;
    localparam logic [7:0] GRPPWM_RST = 8'hFF;
    localparam logic [7:0] LEDOUT_RST = 8'h00;

endpackage

// File: rtl/led_reg_pwm_if.sv
// Single-cycle register strobe bus between the I2C controller (master)
// and the LED register file (slave).
interface led_reg_pwm_if;

    logic [2:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_write,
        output reg_read,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_write,
        input  reg_read,
        output reg_rdata
    );

endinterface

// File: rtl/led_pwm_channel.sv
// One LED output: shadowed duty, LEDOUT mode decode and a registered drive bit.
// The compare uses the shadow so duty changes land only on period boundaries.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_osc,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] duty,
    input  ledout_mode_e     mode,
    input  logic [CNT_W-1:0] cnt,
    input  logic             grp_gate,
    input  logic             sleep,
    output logic             led
);

    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             led_q, led_d;
    logic             lit;

    always_comb begin
        duty_sh_d = load ? duty : duty_sh_q;
        lit       = (cnt < duty_sh_q);
        led_d     = 1'b0;
        case (mode)
            OFF:     led_d = 1'b0;
            ON:      led_d = 1'b1;
            PWM:     led_d = lit;
            GRP:     led_d = lit && grp_gate;
            default: led_d = 1'b0;
        endcase
        if (sleep) begin
            led_d = 1'b0;
        end
    end

    always_ff @(posedge clk_osc or negedge reset_n) begin
        if (!reset_n) begin
            duty_sh_q <= CNT_W'(PWM_RST);
            led_q     <= 1'b0;
        end else begin
            duty_sh_q <= duty_sh_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_reg_pwm.sv
// LED register file (0x0-0x7) and PWM engine clocked from the 400 kHz oscillator.
// Owns the registers, read mux, cnt/gcnt counters and the group duty shadow.
module led_reg_pwm
    import led_pkg::*;
#(
    parameter int         CNT_W    = 8,
    parameter logic [7:0] ID_VALUE = 8'h96
) (
    input  logic          clk_osc,
    input  logic          reset_n,
    led_reg_pwm_if.slave  bus,
    output logic          sleep,
    output logic [3:0]    leds
);

    logic [7:0]       mode_q, mode_d;
    logic [3:0][7:0]  pwm_q, pwm_d;
    logic [7:0]       grp_q, grp_d;
    logic [7:0]       ledout_q, ledout_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] grp_sh_q, grp_sh_d;
    logic             sleep_q, sleep_d;
    logic             sleep_now;
    logic             wrap;
    logic             load;
    logic             grp_gate;

    always_comb begin
        mode_d   = mode_q;
        pwm_d    = pwm_q;
        grp_d    = grp_q;
        ledout_d = ledout_q;
        if (bus.reg_write) begin
            case (bus.reg_addr)
                ADDR_MODE:   mode_d    = bus.reg_wdata;
                ADDR_PWM0:   pwm_d[0]  = bus.reg_wdata;
                ADDR_PWM1:   pwm_d[1]  = bus.reg_wdata;
                ADDR_PWM2:   pwm_d[2]  = bus.reg_wdata;
                ADDR_PWM3:   pwm_d[3]  = bus.reg_wdata;
                ADDR_GRPPWM: grp_d     = bus.reg_wdata;
                ADDR_LEDOUT: ledout_d  = bus.reg_wdata;
                default:     ;
            endcase
        end

        // Reads see the registers before any same-cycle write lands.
        rdata_d = rdata_q;
        if (bus.reg_read) begin
            case (bus.reg_addr)
                ADDR_MODE:   rdata_d = mode_q;
                ADDR_PWM0:   rdata_d = pwm_q[0];
                ADDR_PWM1:   rdata_d = pwm_q[1];
                ADDR_PWM2:   rdata_d = pwm_q[2];
                ADDR_PWM3:   rdata_d = pwm_q[3];
                ADDR_GRPPWM: rdata_d = grp_q;
                ADDR_LEDOUT: rdata_d = ledout_q;
                default:     rdata_d = ID_VALUE;
            endcase
        end

        sleep_now = mode_q[SLEEP_BIT];
        wrap      = (cnt_q == '1);
        load      = sleep_now || wrap;
        grp_gate  = (gcnt_q < grp_sh_q);
        sleep_d   = sleep_now;

        cnt_d    = sleep_now ? '0 : cnt_q + 1'b1;
        gcnt_d   = sleep_now ? '0 : (wrap ? gcnt_q + 1'b1 : gcnt_q);
        grp_sh_d = load ? CNT_W'(grp_q) : grp_sh_q;
    end

    always_ff @(posedge clk_osc or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= MODE_RST;
            pwm_q    <= {4{PWM_RST}};
            grp_q    <= GRPPWM_RST;
            ledout_q <= LEDOUT_RST;
            rdata_q  <= 8'h00;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            grp_sh_q <= CNT_W'(GRPPWM_RST);
            sleep_q  <= MODE_RST[SLEEP_BIT];
        end else begin
            mode_q   <= mode_d;
            pwm_q    <= pwm_d;
            grp_q    <= grp_d;
            ledout_q <= ledout_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            grp_sh_q <= grp_sh_d;
            sleep_q  <= sleep_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        led_pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_osc  (clk_osc),
            .reset_n  (reset_n),
            .load     (load),
            .duty     (CNT_W'(pwm_q[i])),
            .mode     (ledout_mode_e'(ledout_q[2*i+1 -: 2])),
            .cnt      (cnt_q),
            .grp_gate (grp_gate),
            .sleep    (sleep_now),
            .led      (leds[i])
        );
    end

    assign bus.reg_rdata = rdata_q;
    assign sleep         = sleep_q;

endmodule
